// File: rtl/pixel_frame_sequencer.sv
// Frame timing controller for the pixel array: erase, exposure, ramp conversion, then readout.
// Define PIXEL_SEQ_ABORT_EN to add an ABORT input that returns a running frame to IDLE.
module pixel_frame_sequencer #(
    parameter int WIDTH                  = 2,
    parameter int HEIGHT                 = 2,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int BIT_DEPTH              = 8,
    parameter int ERASE_CYCLES           = 4
) (
    input  logic                 SYSTEM_CLK,
    input  logic                 SYSTEM_RESET,
    input  logic                 START,
    input  logic                 CONTINUOUS,
    input  logic [15:0]          EXPOSE_TIME,
`ifdef PIXEL_SEQ_ABORT_EN
    input  logic                 ABORT,
`endif
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic                 POWER_ENABLE,
    output logic                 ERASE,
    output logic                 EXPOSE,
    output logic                 VBN1,
    output logic                 COUNTER_RESET,
    output logic                 WRITE_ENABLE,
    output logic                 COUNTER_CLOCK,
    output logic [BIT_DEPTH-1:0] RAMP_CODE,
    output logic                 READ_RESET,
    output logic                 READ_CLK_IN
);

    localparam int NWORDS   = (WIDTH * HEIGHT) / OUTPUT_BUS_PIXEL_WIDTH;
    localparam int CONV_LEN = 2 * (2 ** BIT_DEPTH);
    localparam int READ_LEN = 2 * NWORDS + 1;
    localparam int MAX_AB   = (ERASE_CYCLES > CONV_LEN) ? ERASE_CYCLES : CONV_LEN;
    localparam int MAX_LEN  = (MAX_AB > READ_LEN) ? MAX_AB : READ_LEN;
    localparam int CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_LEN - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_LEN - 1);
    localparam logic [BIT_DEPTH-1:0] RAMP_MAX = {BIT_DEPTH{1'b1}};

    generate
        if ((WIDTH * HEIGHT) % OUTPUT_BUS_PIXEL_WIDTH != 0) begin : g_bad_bus_width
            $error("WIDTH*HEIGHT must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
        end
        if (ERASE_CYCLES < 1) begin : g_bad_erase
            $error("ERASE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [15:0]          exp_cnt_reg, exp_cnt_next;
    logic [15:0]          exp_len_reg, exp_len_next;
    logic                 done_next;
    logic [BIT_DEPTH-1:0] ramp_reg, ramp_next;
    logic                 cclk_reg;

    logic busy_reg, done_reg, power_reg, erase_reg, expose_reg, vbn1_reg;
    logic cnt_rst_reg, we_reg, read_rst_reg, read_clk_reg;

    // Next-state and phase counters; outputs below are decoded from these so they are registered.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        exp_cnt_next = exp_cnt_reg;
        exp_len_next = exp_len_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    state_next   = ST_ERASE;
                    cnt_next     = '0;
                    exp_len_next = (EXPOSE_TIME == 16'd0) ? 16'd1 : EXPOSE_TIME;
                end
            end
            ST_ERASE: begin
                if (cnt_reg == ERASE_LAST) begin
                    state_next   = ST_EXPOSE;
                    cnt_next     = '0;
                    exp_cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_EXPOSE: begin
                if (exp_cnt_reg == exp_len_reg - 16'd1) begin
                    state_next   = ST_CONVERT;
                    cnt_next     = '0;
                    exp_cnt_next = '0;
                end else begin
                    exp_cnt_next = exp_cnt_reg + 16'd1;
                end
            end
            ST_CONVERT: begin
                if (cnt_reg == CONV_LAST) begin
                    state_next = ST_READ;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_READ: begin
                if (cnt_reg == READ_LAST) begin
                    done_next = 1'b1;
                    cnt_next  = '0;
                    if (CONTINUOUS) begin
                        state_next   = ST_ERASE;
                        exp_len_next = (EXPOSE_TIME == 16'd0) ? 16'd1 : EXPOSE_TIME;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
`ifdef PIXEL_SEQ_ABORT_EN
        // Abort wins over everything, including a continuous restart.
        if (ABORT && (state_reg != ST_IDLE)) begin
            state_next   = ST_IDLE;
            cnt_next     = '0;
            exp_cnt_next = '0;
            exp_len_next = exp_len_reg;
            done_next    = 1'b0;
        end
`endif
    end

    // Ramp steps after each high COUNTER_CLOCK cycle and saturates rather than wrapping.
    always_comb begin
        ramp_next = '0;
        if (state_next == ST_CONVERT) begin
            ramp_next = ramp_reg;
            if ((state_reg == ST_CONVERT) && cclk_reg && (ramp_reg != RAMP_MAX)) begin
                ramp_next = ramp_reg + BIT_DEPTH'(1);
            end
        end
    end

    always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
        if (!SYSTEM_RESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            exp_cnt_reg  <= '0;
            exp_len_reg  <= '0;
            ramp_reg     <= '0;
            cclk_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            power_reg    <= 1'b0;
            erase_reg    <= 1'b0;
            expose_reg   <= 1'b0;
            vbn1_reg     <= 1'b0;
            cnt_rst_reg  <= 1'b0;
            we_reg       <= 1'b0;
            read_rst_reg <= 1'b0;
            read_clk_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            exp_cnt_reg  <= exp_cnt_next;
            exp_len_reg  <= exp_len_next;
            ramp_reg     <= ramp_next;
            cclk_reg     <= (state_next == ST_CONVERT) && cnt_next[0];
            busy_reg     <= (state_next != ST_IDLE);
            done_reg     <= done_next;
            power_reg    <= (state_next == ST_ERASE) || (state_next == ST_EXPOSE) ||
                            (state_next == ST_CONVERT);
            erase_reg    <= (state_next == ST_ERASE);
            expose_reg   <= (state_next == ST_EXPOSE);
            vbn1_reg     <= (state_next == ST_CONVERT);
            cnt_rst_reg  <= (state_next == ST_ERASE);
            we_reg       <= (state_next == ST_CONVERT);
            read_rst_reg <= (state_next == ST_READ) && (cnt_next == '0);
            // Odd read slots are the high half of each word strobe.
            read_clk_reg <= (state_next == ST_READ) && cnt_next[0];
        end
    end

    assign BUSY          = busy_reg;
    assign FRAME_DONE    = done_reg;
    assign POWER_ENABLE  = power_reg;
    assign ERASE         = erase_reg;
    assign EXPOSE        = expose_reg;
    assign VBN1          = vbn1_reg;
    assign COUNTER_RESET = cnt_rst_reg;
    assign WRITE_ENABLE  = we_reg;
    assign COUNTER_CLOCK = cclk_reg;
    assign RAMP_CODE     = ramp_reg;
    assign READ_RESET    = read_rst_reg;
    assign READ_CLK_IN   = read_clk_reg;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench for pixel_frame_sequencer: expected per-cycle output vectors are queued
// when a frame is requested and popped/compared each cycle, 1 time unit after the rising edge.
module tb_pixel_frame_sequencer;

    localparam int E = 4;
    localparam int C = 512;
    localparam int R = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [15:0] exp_time = 16'd0;
`ifdef PIXEL_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    logic busy, frame_done, power_en, erase, expose, vbn1, cnt_rst, wr_en, cnt_clk, rd_rst, rd_clk;
    logic [7:0] ramp;

    pixel_frame_sequencer dut (
        .SYSTEM_CLK    (clk),
        .SYSTEM_RESET  (rst_n),
        .START         (start),
        .CONTINUOUS    (cont),
        .EXPOSE_TIME   (exp_time),
`ifdef PIXEL_SEQ_ABORT_EN
        .ABORT         (abort),
`endif
        .BUSY          (busy),
        .FRAME_DONE    (frame_done),
        .POWER_ENABLE  (power_en),
        .ERASE         (erase),
        .EXPOSE        (expose),
        .VBN1          (vbn1),
        .COUNTER_RESET (cnt_rst),
        .WRITE_ENABLE  (wr_en),
        .COUNTER_CLOCK (cnt_clk),
        .RAMP_CODE     (ramp),
        .READ_RESET    (rd_rst),
        .READ_CLK_IN   (rd_clk)
    );

    always #5 clk = ~clk;

    // Bit map: 18 busy, 17 done, 16 power, 15 erase, 14 expose, 13 vbn1, 12 counter_reset,
    // 11 write_enable, 10 counter_clock, 9 read_reset, 8 read_clk, 7:0 ramp.
    logic [18:0] out_vec;
    assign out_vec = {busy, frame_done, power_en, erase, expose, vbn1, cnt_rst, wr_en,
                      cnt_clk, rd_rst, rd_clk, ramp};

    logic [18:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          rise_cnt = 0;
    logic        prev_cc = 1'b0;
    logic [7:0]  ramp_max = 8'd0;
    string       cur_tag = "init";

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, expv);
        end
    endtask

    task automatic push_frame(input int x, input bit done_first);
        int xl;
        int u;
        logic [18:0] v;
        xl = (x == 0) ? 1 : x;
        for (int t = 1; t <= E + xl + C + R; t++) begin
            v = '0;
            v[18] = 1'b1;
            if (t <= E) begin
                v[16] = 1'b1; v[15] = 1'b1; v[12] = 1'b1;
            end else if (t <= E + xl) begin
                v[16] = 1'b1; v[14] = 1'b1;
            end else if (t <= E + xl + C) begin
                u = t - E - xl - 1;
                v[16] = 1'b1; v[13] = 1'b1; v[11] = 1'b1;
                v[10] = (u % 2 == 1);
                v[7:0] = 8'(u / 2);
            end else begin
                u = t - E - xl - C - 1;
                v[9] = (u == 0);
                v[8] = (u % 2 == 1);
            end
            if (t == 1) v[17] = done_first;
            exp_q.push_back(v);
        end
    endtask

    task automatic push_idle(input int n, input bit done_first);
        logic [18:0] v;
        for (int i = 0; i < n; i++) begin
            v = '0;
            if (i == 0) v[17] = done_first;
            exp_q.push_back(v);
        end
    endtask

    task automatic tick();
        logic [18:0] expv;
        @(posedge clk);
        #1;
        if (out_vec[10] && !prev_cc) rise_cnt++;
        prev_cc = out_vec[10];
        if (out_vec[7:0] > ramp_max) ramp_max = out_vec[7:0];
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_underflow_%s t=%0t observed=%h expected=<queued value>", cur_tag, $time, out_vec);
        end else begin
            expv = exp_q.pop_front();
            check(cur_tag, out_vec, expv);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) tick();
    endtask

    initial begin
        // Reset state
        #1;
        check("reset_async", out_vec, 19'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", out_vec, 19'h0);
        end
        rst_n = 1'b1;
        cur_tag = "idle";
        push_idle(2, 1'b0);
        drain();
        $display("[TB] step reset/idle done");

        // Single frame with full timing and ramp profile
        cur_tag = "single_frame";
        rise_cnt = 0;
        ramp_max = 8'd0;
        exp_time = 16'd10;
        push_frame(10, 1'b0);
        push_idle(3, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain();
        check_int("counter_clock_rises", rise_cnt, 256);
        check_int("ramp_peak", int'(ramp_max), 255);
        $display("[TB] step single frame, expose=10");

        // Continuous capture with exposure re-latched at the restart
        cur_tag = "continuous";
        cont = 1'b1;
        exp_time = 16'd10;
        push_frame(10, 1'b0);
        push_frame(3, 1'b1);
        push_idle(2, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        exp_time = 16'd3;
        repeat (535) tick();
        cont = 1'b0;
        drain();
        $display("[TB] step continuous frames, expose 10 then 3");

        // Zero exposure and START pulses mid-frame
        cur_tag = "zero_expose";
        exp_time = 16'd0;
        push_frame(0, 1'b0);
        push_idle(6, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        drain();
        $display("[TB] step zero exposure, ignored START pulses");

        // Reset mid-CONVERT, then a normal frame
        cur_tag = "pre_reset";
        exp_time = 16'd10;
        push_frame(10, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (214) tick();
        check_int("ramp_before_reset", int'(ramp), 100);
        rst_n = 1'b0;
        #1;
        check("reset_mid_async", out_vec, 19'h0);
        exp_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_mid_hold", out_vec, 19'h0);
        end
        rst_n = 1'b1;
        cur_tag = "post_reset_idle";
        push_idle(2, 1'b0);
        drain();
        cur_tag = "post_reset_frame";
        push_frame(10, 1'b0);
        push_idle(2, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain();
        $display("[TB] step reset during convert, recovery frame");

`ifdef PIXEL_SEQ_ABORT_EN
        cur_tag = "pre_abort";
        push_frame(10, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        exp_q.delete();
        cur_tag = "abort";
        push_idle(1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        push_idle(3, 1'b0);
        drain();
        $display("[TB] step abort during expose");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
